alu_control_pipe: RTL and testbench
===================================

Name: alu_control_pipe

Overview:
- Parametrised, registered successor of ALU_Control for the RISC-V core.
- Decodes {aluop_d, funct7_5, funct3} into the ALU control code, covering RV32I and the M extension.
- Registers the result into the D->E pipeline boundary with valid, stall and flush handling.
- Sequences multi-cycle MUL/DIV operations with a latency counter and a stall request back to decode.

Parameters:
- CTRL_W, 5, alucontrol_e width; must be >= 5; upper bits are zero-filled.
- MUL_LAT, 3, cycles a MUL/MULH/MULHSU/MULHU occupies the E stage; must be >= 1.
- DIV_LAT, 32, cycles a DIV/DIVU/REM/REMU occupies the E stage; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_d  in  1  decode-stage instruction valid.
- aluop_d  in  4  main-decoder ALU op class.
- funct7_5  in  1  instr[30].
- funct7_0  in  1  instr[25], the M-extension select.
- funct3  in  3  instr[14:12].
- stall_e  in  1  downstream stall; hold E registers.
- flush_e  in  1  squash the E stage and abort any M sequence.
- valid_e  out  1  E-stage control valid.
- alucontrol_e  out  CTRL_W  registered ALU control code.
- illegal_e  out  1  registered: aluop_d class was undefined.
- md_start  out  1  one-cycle pulse when an M op enters E.
- md_busy  out  1  FSM in BUSY.
- stall_req  out  1  stall request to fetch/decode.

Behaviour:
- Reset (rst=1 at an edge): valid_e=0, alucontrol_e=0, illegal_e=0, md_start=0, state=IDLE, counter=0. Reset overrides everything, including mid-sequence.

Decode (combinational, 5-bit code):
- aluop 0000 (address add): 00000.
- aluop 0010 (R-type), funct7_0=0: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001.
  - funct7_5 selects SUB and SRA only.
- aluop 0010 with funct7_0=1 (M ops): code = 10100 + funct3, giving 10100..11011.
- aluop 0011 (I-type ALU): same table as R-type. funct7_5 is honoured only for funct3=101 (SRAI); ADDI is always ADD.
- aluop 0111 (LUI): 11111.
- aluop 1100 (branch):
  - BEQ/BNE: 10000.
  - BLT/BGE: 10001.
  - BLTU/BGEU: 10010.
  - funct3 010/011: 10000 with illegal=1.
- Any other aluop: 00000 with illegal=1.

Pipeline register:
- accept = valid_d & ~stall_req & ~stall_e & ~flush_e.
- Priority at each edge: rst > flush_e > stall_e > accept.
- On accept: valid_e, alucontrol_e and illegal_e load from decode at the next edge (latency 1 cycle).
- valid_d=0 with no stall: valid_e goes to 0 next edge; alucontrol_e holds its value.
- stall_e=1: all E registers hold.
- flush_e=1: valid_e=0 and illegal_e=0 next edge; FSM to IDLE; counter cleared; md_start=0.

M-op FSM (states IDLE, BUSY):
- On accepting an M op: next edge md_start=1 for exactly one cycle and valid_e=1.
  - LAT = MUL_LAT if funct3[2]=0, else DIV_LAT.
  - If LAT>1: state goes to BUSY and counter = LAT-1.
- In BUSY:
  - stall_req=1 and md_busy=1.
  - Counter decrements every cycle, even while stall_e=1.
  - When counter==1 the FSM returns to IDLE at the next edge; the counter reaches 0.
- stall_req is high for exactly LAT-1 cycles, beginning in the cycle md_start is high. The M op occupies E for LAT cycles.
- valid_e, alucontrol_e and illegal_e hold throughout BUSY.
- A new accept is possible in the cycle after BUSY exits.
- With LAT=1: no BUSY; md_start still pulses.
- Non-M ops never enter BUSY; stall_req=0 in IDLE.

Test Plan:
- Reset, then valid_d=1, aluop_d=0111, funct7_5=1, funct3=000 -> one edge later valid_e=1, alucontrol_e=11111, illegal_e=0, stall_req=0.
- Next cycle aluop_d=1100, funct7_5=1, funct3=001 (BNE) -> alucontrol_e=10000. Then aluop 0010, funct7_5=1, funct3=101 -> 00111 (SRA). Then aluop 0011, funct7_5=1, funct3=000 -> 00000 (ADDI).
- aluop 0010, funct7_0=1, funct3=100 (DIV), DIV_LAT=32 -> alucontrol_e=11000, md_start high 1 cycle, stall_req and md_busy high 31 consecutive cycles, then 0. The next instruction is accepted on the following edge.
- MUL (funct3=000), MUL_LAT=3 -> code 10100, stall_req high 2 cycles. Assert stall_e during BUSY -> the counter still expires after 2 cycles and E registers hold.
- flush_e asserted during DIV BUSY (cycle 5) -> next edge valid_e=0, md_busy=0, stall_req=0. Repeat with rst mid-BUSY -> all outputs 0.
- aluop 1111 -> illegal_e=1, alucontrol_e=00000. Then valid_d=0 -> valid_e=0 next edge and alucontrol_e unchanged.

Source files
------------

// File: rtl/alu_control_pipe.sv
// ALU control decode (RV32I + M) registered into the D->E boundary, with a
// latency counter that holds decode off while a multi-cycle MUL/DIV occupies E.
module alu_control_pipe #(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [3:0]        aluop_d,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic [2:0]        funct3,
    input  logic              stall_e,
    input  logic              flush_e,
    output logic              valid_e,
    output logic [CTRL_W-1:0] alucontrol_e,
    output logic              illegal_e,
    output logic              md_start,
    output logic              md_busy,
    output logic              stall_req
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d_n;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;
    logic              md_start_q, md_start_d;

    logic [4:0]        dec_code;
    logic              dec_illegal;
    logic              dec_is_m;
    logic              alt_sel;
    logic [4:0]        base_code;
    logic              accept;
    logic [CNT_W-1:0]  m_cnt;

    // funct7_5 only picks SUB/SRA; I-type honours it only for SRAI.
    assign alt_sel = funct7_5 & ((aluop_d == 4'b0010) | (funct3 == 3'b101));

    always_comb begin
        base_code = 5'b00000;
        case (funct3)
            3'b000: base_code = alt_sel ? 5'b00001 : 5'b00000;
            3'b001: base_code = 5'b00010;
            3'b010: base_code = 5'b00011;
            3'b011: base_code = 5'b00100;
            3'b100: base_code = 5'b00101;
            3'b101: base_code = alt_sel ? 5'b00111 : 5'b00110;
            3'b110: base_code = 5'b01000;
            3'b111: base_code = 5'b01001;
            default: base_code = 5'b00000;
        endcase
    end

    always_comb begin
        dec_code    = 5'b00000;
        dec_illegal = 1'b0;
        dec_is_m    = 1'b0;
        case (aluop_d)
            4'b0000: dec_code = 5'b00000;
            4'b0010: begin
                if (funct7_0) begin
                    dec_code = 5'b10100 + {2'b00, funct3};
                    dec_is_m = 1'b1;
                end else begin
                    dec_code = base_code;
                end
            end
            4'b0011: dec_code = base_code;
            4'b0111: dec_code = 5'b11111;
            4'b1100: begin
                case (funct3[2:1])
                    2'b00: dec_code = 5'b10000;
                    2'b01: begin
                        dec_code    = 5'b10000;
                        dec_illegal = 1'b1;
                    end
                    2'b10: dec_code = 5'b10001;
                    default: dec_code = 5'b10010;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign accept = valid_d & ~stall_req & ~stall_e & ~flush_e;
    assign m_cnt  = funct3[2] ? DIV_CNT : MUL_CNT;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d_n  = valid_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        md_start_d = 1'b0;
        if (flush_e) begin
            valid_d_n = 1'b0;
            illegal_d = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
        end else begin
            // The counter runs through downstream stalls so the op's latency is fixed.
            if (state_q == BUSY) begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end
            end
            if (stall_e) begin
                // E registers hold.
            end else if (accept) begin
                valid_d_n = 1'b1;
                ctrl_d    = CTRL_W'(dec_code);
                illegal_d = dec_illegal;
                if (dec_is_m) begin
                    md_start_d = 1'b1;
                    if (m_cnt != '0) begin
                        state_d = BUSY;
                        cnt_d   = m_cnt;
                    end
                end
            end else if (state_q == IDLE) begin
                valid_d_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d_n;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            md_start_q <= md_start_d;
        end
    end

    assign valid_e      = valid_q;
    assign alucontrol_e = ctrl_q;
    assign illegal_e    = illegal_q;
    assign md_start     = md_start_q;
    assign md_busy      = (state_q == BUSY);
    assign stall_req    = (state_q == BUSY);

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: decode table, pipeline register
// behaviour, MUL/DIV latency sequencing, flush and reset.
module tb_alu_control_pipe;

    localparam int CTRL_W  = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;
    localparam int W       = 7;

    logic              clk;
    logic              rst;
    logic              valid_d;
    logic [3:0]        aluop_d;
    logic              funct7_5;
    logic              funct7_0;
    logic [2:0]        funct3;
    logic              stall_e;
    logic              flush_e;
    logic              valid_e;
    logic [CTRL_W-1:0] alucontrol_e;
    logic              illegal_e;
    logic              md_start;
    logic              md_busy;
    logic              stall_req;

    int n_cmp;
    int n_mis;
    logic [W-1:0] exp_q[$];

    alu_control_pipe #(
        .CTRL_W (CTRL_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_d     (valid_d),
        .aluop_d     (aluop_d),
        .funct7_5    (funct7_5),
        .funct7_0    (funct7_0),
        .funct3      (funct3),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .valid_e     (valid_e),
        .alucontrol_e(alucontrol_e),
        .illegal_e   (illegal_e),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .stall_req   (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: returns {illegal, code}.
    function automatic logic [5:0] ref_decode(input logic [3:0] op, input logic f75,
                                              input logic f70, input logic [2:0] f3);
        logic [4:0] tab [8];
        tab = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        case (op)
            4'b0000: return 6'b000000;
            4'b0010: begin
                if (f70) return {1'b0, 5'd20 + {2'b00, f3}};
                if (f75 && f3 == 3'd0) return 6'd1;
                if (f75 && f3 == 3'd5) return 6'd7;
                return {1'b0, tab[f3]};
            end
            4'b0011: begin
                if (f75 && f3 == 3'd5) return 6'd7;
                return {1'b0, tab[f3]};
            end
            4'b0111: return 6'b011111;
            4'b1100: begin
                case (f3[2:1])
                    2'b00: return 6'b010000;
                    2'b01: return 6'b110000;
                    2'b10: return 6'b010001;
                    default: return 6'b010010;
                endcase
            end
            default: return 6'b100000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic f75,
                         input logic f70, input logic [2:0] f3);
        valid_d  = v;
        aluop_d  = op;
        funct7_5 = f75;
        funct7_0 = f70;
        funct3   = f3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        stall_e = 1'b0;
        flush_e = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({valid_e, alucontrol_e, illegal_e, md_start, md_busy, stall_req} !== 10'b0) begin
            $display("FAIL reset: got v=%b c=%b il=%b st=%b bz=%b sr=%b, want all 0",
                     valid_e, alucontrol_e, illegal_e, md_start, md_busy, stall_req);
            n_mis++;
        end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [W-1:0] e;
        // LUI, BNE, SRA, ADDI with funct7_5 set.
        logic [3:0] ops [4];
        logic [2:0] f3s [4];
        logic [4:0] want [4];
        ops  = '{4'b0111, 4'b1100, 4'b0010, 4'b0011};
        f3s  = '{3'b000, 3'b001, 3'b101, 3'b000};
        want = '{5'b11111, 5'b10000, 5'b00111, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 1'b1, 1'b0, f3s[i]);
            exp_q.push_back({1'b1, 1'b0, want[i]});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({valid_e, illegal_e, alucontrol_e} !== e || stall_req !== 1'b0 || md_start !== 1'b0) begin
                $display("FAIL decode_%0d: got v=%b il=%b c=%b sr=%b st=%b, want v=%b il=%b c=%b sr=0 st=0",
                         i, valid_e, illegal_e, alucontrol_e, stall_req, md_start, e[6], e[5], e[4:0]);
                n_mis++;
            end
        end
    endtask

    task automatic test_div();
        int busy_cycles;
        drive(1'b1, 4'b0010, 1'b0, 1'b1, 3'b100);
        tick();
        drive(1'b1, 4'b0010, 1'b0, 1'b0, 3'b100);
        n_cmp++;
        if (alucontrol_e !== 5'b11000 || valid_e !== 1'b1 || md_start !== 1'b1 ||
            stall_req !== 1'b1 || md_busy !== 1'b1) begin
            $display("FAIL div_start: got c=%b v=%b st=%b sr=%b bz=%b, want c=11000 v=1 st=1 sr=1 bz=1",
                     alucontrol_e, valid_e, md_start, stall_req, md_busy);
            n_mis++;
        end
        busy_cycles = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stall_req !== 1'b1) break;
            busy_cycles++;
            if (md_start !== 1'b0 || alucontrol_e !== 5'b11000 || md_busy !== 1'b1) begin
                n_cmp++;
                $display("FAIL div_hold: got st=%b c=%b bz=%b, want st=0 c=11000 bz=1",
                         md_start, alucontrol_e, md_busy);
                n_mis++;
            end
        end
        n_cmp++;
        if (busy_cycles != DIV_LAT - 1) begin
            $display("FAIL div_stall_len: got %0d cycles, want %0d", busy_cycles, DIV_LAT - 1);
            n_mis++;
        end
        n_cmp++;
        if (md_busy !== 1'b0 || alucontrol_e !== 5'b11000 || valid_e !== 1'b1) begin
            $display("FAIL div_exit: got bz=%b c=%b v=%b, want bz=0 c=11000 v=1",
                     md_busy, alucontrol_e, valid_e);
            n_mis++;
        end
        exp_q.push_back({1'b1, 1'b0, 5'b00101});
        tick();
        begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({valid_e, illegal_e, alucontrol_e} !== e) begin
                $display("FAIL div_next_accept: got v=%b il=%b c=%b, want v=%b il=%b c=%b",
                         valid_e, illegal_e, alucontrol_e, e[6], e[5], e[4:0]);
                n_mis++;
            end
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        tick();
    endtask

    task automatic test_mul_stall();
        drive(1'b1, 4'b0010, 1'b0, 1'b1, 3'b000);
        tick();
        stall_e = 1'b1;
        drive(1'b1, 4'b0111, 1'b0, 1'b0, 3'b000);
        n_cmp++;
        if (alucontrol_e !== 5'b10100 || md_start !== 1'b1 || stall_req !== 1'b1 || valid_e !== 1'b1) begin
            $display("FAIL mul_start: got c=%b st=%b sr=%b v=%b, want c=10100 st=1 sr=1 v=1",
                     alucontrol_e, md_start, stall_req, valid_e);
            n_mis++;
        end
        tick();
        n_cmp++;
        if (stall_req !== 1'b1 || md_start !== 1'b0 || alucontrol_e !== 5'b10100) begin
            $display("FAIL mul_busy2: got sr=%b st=%b c=%b, want sr=1 st=0 c=10100",
                     stall_req, md_start, alucontrol_e);
            n_mis++;
        end
        tick();
        n_cmp++;
        if (stall_req !== 1'b0 || md_busy !== 1'b0 || valid_e !== 1'b1 || alucontrol_e !== 5'b10100) begin
            $display("FAIL mul_expire_under_stall: got sr=%b bz=%b v=%b c=%b, want sr=0 bz=0 v=1 c=10100",
                     stall_req, md_busy, valid_e, alucontrol_e);
            n_mis++;
        end
        tick();
        n_cmp++;
        if (valid_e !== 1'b1 || alucontrol_e !== 5'b10100) begin
            $display("FAIL stall_hold: got v=%b c=%b, want v=1 c=10100", valid_e, alucontrol_e);
            n_mis++;
        end
        stall_e = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        tick();
        n_cmp++;
        if (valid_e !== 1'b0 || alucontrol_e !== 5'b10100) begin
            $display("FAIL mul_drain: got v=%b c=%b, want v=0 c=10100", valid_e, alucontrol_e);
            n_mis++;
        end
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 4'b0010, 1'b0, 1'b1, 3'b110);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (md_busy !== 1'b1 || alucontrol_e !== 5'b11010) begin
            $display("FAIL flush_pre: got bz=%b c=%b, want bz=1 c=11010", md_busy, alucontrol_e);
            n_mis++;
        end
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        n_cmp++;
        if (valid_e !== 1'b0 || md_busy !== 1'b0 || stall_req !== 1'b0 ||
            illegal_e !== 1'b0 || md_start !== 1'b0) begin
            $display("FAIL flush: got v=%b bz=%b sr=%b il=%b st=%b, want all 0",
                     valid_e, md_busy, stall_req, illegal_e, md_start);
            n_mis++;
        end
        drive(1'b1, 4'b0010, 1'b0, 1'b1, 3'b111);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({valid_e, alucontrol_e, illegal_e, md_start, md_busy, stall_req} !== 10'b0) begin
            $display("FAIL reset_mid_busy: got v=%b c=%b il=%b st=%b bz=%b sr=%b, want all 0",
                     valid_e, alucontrol_e, illegal_e, md_start, md_busy, stall_req);
            n_mis++;
        end
        tick();
        n_cmp++;
        if (md_busy !== 1'b0 || stall_req !== 1'b0) begin
            $display("FAIL reset_stays_idle: got bz=%b sr=%b, want 0 0", md_busy, stall_req);
            n_mis++;
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'b1111, 1'b0, 1'b0, 3'b000);
        tick();
        n_cmp++;
        if (illegal_e !== 1'b1 || alucontrol_e !== 5'b00000 || valid_e !== 1'b1) begin
            $display("FAIL illegal_op: got il=%b c=%b v=%b, want il=1 c=00000 v=1",
                     illegal_e, alucontrol_e, valid_e);
            n_mis++;
        end
        drive(1'b1, 4'b1100, 1'b0, 1'b0, 3'b011);
        tick();
        n_cmp++;
        if (illegal_e !== 1'b1 || alucontrol_e !== 5'b10000) begin
            $display("FAIL illegal_branch: got il=%b c=%b, want il=1 c=10000", illegal_e, alucontrol_e);
            n_mis++;
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        tick();
        n_cmp++;
        if (valid_e !== 1'b0 || alucontrol_e !== 5'b10000) begin
            $display("FAIL bubble_hold: got v=%b c=%b, want v=0 c=10000", valid_e, alucontrol_e);
            n_mis++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op_set [6];
        logic [3:0] op;
        logic       v, f75, f70;
        logic [2:0] f3;
        logic [5:0] r;
        logic [4:0] last_code;
        logic [W-1:0] e;
        op_set = '{4'b0000, 4'b0010, 4'b0011, 4'b0111, 4'b1100, 4'b0101};
        last_code = alucontrol_e;
        for (int i = 0; i < 60; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = op_set[$urandom_range(0, 5)];
            f75 = 1'($urandom_range(0, 1));
            f70 = (op == 4'b0010) ? 1'b0 : 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            drive(v, op, f75, f70, f3);
            if (v) begin
                r = ref_decode(op, f75, f70, f3);
                exp_q.push_back({1'b1, r});
                last_code = r[4:0];
            end else begin
                exp_q.push_back({1'b0, 1'b0, last_code});
            end
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (e[6] ? ({valid_e, illegal_e, alucontrol_e} !== e)
                     : ({valid_e, alucontrol_e} !== {e[6], e[4:0]})) begin
                $display("FAIL b2b_%0d: got v=%b il=%b c=%b, want v=%b il=%b c=%b (op=%b f3=%b f75=%b)",
                         i, valid_e, illegal_e, alucontrol_e, e[6], e[5], e[4:0], op, f3, f75);
                n_mis++;
            end
            if (stall_req !== 1'b0 || md_start !== 1'b0) begin
                n_cmp++;
                $display("FAIL b2b_no_md_%0d: got sr=%b st=%b, want 0 0", i, stall_req, md_start);
                n_mis++;
            end
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        rst     = 1'b1;
        stall_e = 1'b0;
        flush_e = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 3'b000);
        test_reset();
        test_decode();
        test_div();
        test_mul_stall();
        test_flush_reset();
        test_illegal();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_cmp++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
            n_mis++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
